// File: rtl/mul_div_unit.sv
`default_nettype none
// ============================================================================
//  Module   : mul_div_unit
//  Purpose  : Iterative MIPS HI/LO multiply/divide unit. Executes
//             MULT/MULTU/DIV/DIVU with a radix-2 shift-add multiplier and a
//             restoring shift-subtract divider, plus single-cycle MTHI/MTLO.
//             Holds architectural HI/LO.
//  Ports    : clk            rising-edge clock
//             rst_n          asynchronous active-low reset
//             start_i        request, sampled only while busy_o=0
//             op_i[2:0]      000 MULT 001 MULTU 010 DIV 011 DIVU 100 MTHI 101 MTLO
//             a_i[XLEN-1:0]  rs operand (multiplicand / dividend / MTxx source)
//             b_i[XLEN-1:0]  rt operand (multiplier / divisor)
//             busy_o         operation in flight, start ignored
//             done_o         one-cycle pulse, hi_o/lo_o hold the new result
//             div_by_zero_o  valid with done_o, DIV/DIVU had b==0
//             hi_o, lo_o     HI / LO registers
//  Config   : MULDIV_FAST_MULT_EN - single-cycle combinational multiply,
//             MULT/MULTU skip the iterative phase.
//  Revision : 1.0 - initial release
// ============================================================================
module mul_div_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start_i,
    input  logic [2:0]      op_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    output logic            busy_o,
    output logic            done_o,
    output logic            div_by_zero_o,
    output logic [XLEN-1:0] hi_o,
    output logic [XLEN-1:0] lo_o
);

    localparam int CW = $clog2(XLEN + 1);

    localparam logic [2:0] C_OP_MULT  = 3'b000;
    localparam logic [2:0] C_OP_MULTU = 3'b001;
    localparam logic [2:0] C_OP_DIV   = 3'b010;
    localparam logic [2:0] C_OP_DIVU  = 3'b011;
    localparam logic [2:0] C_OP_MTHI  = 3'b100;
    localparam logic [2:0] C_OP_MTLO  = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CALC  = 2'd1,
        S_FIXUP = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                dbz_q, dbz_d;
    logic                mt_pend_q, mt_pend_d;   // MTHI/MTLO done pulse owed
    logic                is_div_q, is_div_d;
    logic                neg_q, neg_d;           // negate product / quotient
    logic                rneg_q, rneg_d;         // negate remainder
    logic                zero_q, zero_d;         // divide-by-zero in flight
    logic [XLEN-1:0]     hi_q, hi_d;
    logic [XLEN-1:0]     lo_q, lo_d;
    logic [XLEN-1:0]     opb_q, opb_d;           // multiplicand or divisor magnitude
    logic [2*XLEN-1:0]   acc_q, acc_d;           // {upper,lower} or {rem,quo}
    logic [CW-1:0]       cnt_q, cnt_d;

    // Operand magnitudes; op_i[0]=0 selects the signed variants
    logic                w_signed, w_a_neg, w_b_neg;
    logic [XLEN-1:0]     w_a_abs, w_b_abs;

    assign w_signed = ~op_i[0];
    assign w_a_neg  = w_signed & a_i[XLEN-1];
    assign w_b_neg  = w_signed & b_i[XLEN-1];
    assign w_a_abs  = w_a_neg ? -a_i : a_i;
    assign w_b_abs  = w_b_neg ? -b_i : b_i;

    // Shift-add step: conditionally add multiplicand to upper half, then
    // shift the whole {carry, upper, lower} right by one.
    logic [XLEN:0]       w_mul_sum;
    logic [2*XLEN-1:0]   w_mul_next;

    assign w_mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : {(XLEN+1){1'b0}});
    assign w_mul_next = {w_mul_sum, acc_q[XLEN-1:1]};

    // Restoring divide step: remainder < divisor is invariant, so the shifted
    // partial remainder fits in XLEN+1 bits and the difference in XLEN bits.
    logic [XLEN:0]       w_div_shift;
    logic [XLEN-1:0]     w_div_diff;
    logic                w_div_ge;
    logic [2*XLEN-1:0]   w_div_next;

    assign w_div_shift = acc_q[2*XLEN-1:XLEN-1];
    assign w_div_diff  = w_div_shift[XLEN-1:0] - opb_q;
    assign w_div_ge    = (w_div_shift >= {1'b0, opb_q});
    assign w_div_next  = w_div_ge ? {w_div_diff, acc_q[XLEN-2:0], 1'b1}
                                  : {w_div_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};

    // Sign correction applied in FIXUP
    logic [2*XLEN-1:0]   w_prod_fix;
    logic [XLEN-1:0]     w_quo_fix, w_rem_fix;

    assign w_prod_fix = neg_q  ? -acc_q : acc_q;
    assign w_quo_fix  = neg_q  ? -acc_q[XLEN-1:0]      : acc_q[XLEN-1:0];
    assign w_rem_fix  = rneg_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];

`ifdef MULDIV_FAST_MULT_EN
    logic [2*XLEN-1:0]   w_fast_prod;
    assign w_fast_prod = {{XLEN{1'b0}}, w_a_abs} * {{XLEN{1'b0}}, w_b_abs};
`endif

    always_comb begin
        state_d   = state_q;
        busy_d    = busy_q;
        done_d    = mt_pend_q;
        dbz_d     = 1'b0;
        mt_pend_d = 1'b0;
        is_div_d  = is_div_q;
        neg_d     = neg_q;
        rneg_d    = rneg_q;
        zero_d    = zero_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        opb_d     = opb_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    case (op_i)
                        C_OP_MULT, C_OP_MULTU: begin
                            busy_d   = 1'b1;
                            is_div_d = 1'b0;
                            neg_d    = w_a_neg ^ w_b_neg;
                            rneg_d   = 1'b0;
                            zero_d   = 1'b0;
`ifdef MULDIV_FAST_MULT_EN
                            acc_d    = w_fast_prod;
                            state_d  = S_FIXUP;
`else
                            acc_d    = {{XLEN{1'b0}}, w_b_abs};
                            opb_d    = w_a_abs;
                            cnt_d    = CW'(XLEN);
                            state_d  = S_CALC;
`endif
                        end
                        C_OP_DIV, C_OP_DIVU: begin
                            busy_d = 1'b1;
                            if (b_i == {XLEN{1'b0}}) begin
                                // Reuse the product write-back path: hi=a, lo=all ones
                                acc_d    = {a_i, {XLEN{1'b1}}};
                                is_div_d = 1'b0;
                                neg_d    = 1'b0;
                                rneg_d   = 1'b0;
                                zero_d   = 1'b1;
                                state_d  = S_FIXUP;
                            end else begin
                                acc_d    = {{XLEN{1'b0}}, w_a_abs};
                                opb_d    = w_b_abs;
                                is_div_d = 1'b1;
                                neg_d    = w_a_neg ^ w_b_neg;
                                rneg_d   = w_a_neg;
                                zero_d   = 1'b0;
                                cnt_d    = CW'(XLEN);
                                state_d  = S_CALC;
                            end
                        end
                        C_OP_MTHI: begin
                            hi_d      = a_i;
                            mt_pend_d = 1'b1;
                        end
                        C_OP_MTLO: begin
                            lo_d      = a_i;
                            mt_pend_d = 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
            S_CALC: begin
                acc_d = is_div_q ? w_div_next : w_mul_next;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = S_FIXUP;
                end
            end
            S_FIXUP: begin
                if (is_div_q) begin
                    hi_d = w_rem_fix;
                    lo_d = w_quo_fix;
                end else begin
                    hi_d = w_prod_fix[2*XLEN-1:XLEN];
                    lo_d = w_prod_fix[XLEN-1:0];
                end
                done_d  = 1'b1;
                dbz_d   = zero_q;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            dbz_q     <= 1'b0;
            mt_pend_q <= 1'b0;
            is_div_q  <= 1'b0;
            neg_q     <= 1'b0;
            rneg_q    <= 1'b0;
            zero_q    <= 1'b0;
            hi_q      <= {XLEN{1'b0}};
            lo_q      <= {XLEN{1'b0}};
            opb_q     <= {XLEN{1'b0}};
            acc_q     <= {(2*XLEN){1'b0}};
            cnt_q     <= {CW{1'b0}};
        end else begin
            state_q   <= state_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            dbz_q     <= dbz_d;
            mt_pend_q <= mt_pend_d;
            is_div_q  <= is_div_d;
            neg_q     <= neg_d;
            rneg_q    <= rneg_d;
            zero_q    <= zero_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            opb_q     <= opb_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
        end
    end

    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign div_by_zero_o = dbz_q;
    assign hi_o          = hi_q;
    assign lo_o          = lo_q;

endmodule
`default_nettype wire

// File: tb/tb_mul_div_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mul_div_unit
//  Purpose  : Self-checking bench for mul_div_unit (XLEN=32). Expected HI/LO,
//             divide-by-zero flag and completion cycle come from a plain
//             arithmetic model and are queued at issue; a monitor pops and
//             compares on every done pulse and tracks the busy window.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mul_div_unit;

    localparam int XLEN = 32;
`ifdef MULDIV_FAST_MULT_EN
    localparam int C_MUL_LAT = 1;
`else
    localparam int C_MUL_LAT = XLEN + 1;
`endif

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            start_i = 1'b0;
    logic [2:0]      op_i = 3'b000;
    logic [XLEN-1:0] a_i = '0;
    logic [XLEN-1:0] b_i = '0;
    logic            busy_o, done_o, div_by_zero_o;
    logic [XLEN-1:0] hi_o, lo_o;

    mul_div_unit #(.XLEN(XLEN)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start_i       (start_i),
        .op_i          (op_i),
        .a_i           (a_i),
        .b_i           (b_i),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .div_by_zero_o (div_by_zero_o),
        .hi_o          (hi_o),
        .lo_o          (lo_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
        int          cyc;
    } exp_t;

    exp_t        sb_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;
    int          busy_lo = 1;
    int          busy_hi = 0;

    // Architectural behaviour of one operation; updates the model HI/LO.
    task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic dbz, output int lat, output logic ok);
        logic [63:0] p;
        longint      sa, sb, q, r;
        ok = 1'b1; dbz = 1'b0; lat = 1;
        case (op)
            3'b000: begin
                sa = longint'($signed(a)); sb = longint'($signed(b));
                q  = sa * sb; p = q;
                m_hi = p[63:32]; m_lo = p[31:0]; lat = C_MUL_LAT;
            end
            3'b001: begin
                p = {32'd0, a} * {32'd0, b};
                m_hi = p[63:32]; m_lo = p[31:0]; lat = C_MUL_LAT;
            end
            3'b010, 3'b011: begin
                if (b == 32'd0) begin
                    m_hi = a; m_lo = 32'hFFFF_FFFF; dbz = 1'b1; lat = 1;
                end else begin
                    if (op == 3'b010) begin
                        sa = longint'($signed(a)); sb = longint'($signed(b));
                    end else begin
                        sa = longint'({32'd0, a}); sb = longint'({32'd0, b});
                    end
                    q = sa / sb; r = sa % sb;
                    m_lo = q[31:0]; m_hi = r[31:0]; lat = XLEN + 1;
                end
            end
            3'b100: m_hi = a;
            3'b101: m_lo = a;
            default: ok = 1'b0;
        endcase
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        logic dbz, ok;
        int   lat;
        model(op, a, b, dbz, lat, ok);
        start_i = 1'b1; op_i = op; a_i = a; b_i = b;
        if (ok) begin
            e.hi = m_hi; e.lo = m_lo; e.dbz = dbz; e.cyc = cyc + 1 + lat;
            sb_q.push_back(e);
            if (op[2] == 1'b0) begin
                busy_lo = cyc + 1;
                busy_hi = cyc + lat;
            end
        end
        @(negedge clk);
        start_i = 1'b0;
        a_i = $urandom; b_i = $urandom; op_i = 3'($urandom_range(0, 7));
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 200 && sb_q.size() != 0; i++) @(negedge clk);
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL timeout: %0d results still pending, required 0", sb_q.size());
            sb_q.delete();
        end
    endtask

    // Monitor: busy window every cycle, scoreboard compare on each done.
    always @(negedge clk) begin
        exp_t e;
        logic exp_busy;
        if (rst_n) begin
            exp_busy = (cyc >= busy_lo) && (cyc <= busy_hi);
            checks++;
            if (busy_o !== exp_busy) begin
                errors++;
                $display("FAIL busy @cyc %0d: got %b, required %b", cyc, busy_o, exp_busy);
            end
            if (done_o === 1'b1) begin
                checks++;
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected done @cyc %0d: got 1, required 0", cyc);
                end else begin
                    e = sb_q.pop_front();
                    if (hi_o !== e.hi || lo_o !== e.lo || div_by_zero_o !== e.dbz) begin
                        errors++;
                        $display("FAIL result: got hi=%h lo=%h dbz=%b, required hi=%h lo=%h dbz=%b",
                                 hi_o, lo_o, div_by_zero_o, e.hi, e.lo, e.dbz);
                    end
                    checks++;
                    if (cyc != e.cyc) begin
                        errors++;
                        $display("FAIL done timing: got cyc %0d, required cyc %0d", cyc, e.cyc);
                    end
                end
            end else if (div_by_zero_o !== 1'b0) begin
                checks++;
                errors++;
                $display("FAIL dbz without done: got %b, required 0", div_by_zero_o);
            end
        end
    end

    function automatic logic [31:0] rnd_val();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        repeat (2) @(negedge clk);
        checks++;
        if (busy_o !== 1'b0 || done_o !== 1'b0 || div_by_zero_o !== 1'b0 ||
            hi_o !== 32'd0 || lo_o !== 32'd0) begin
            errors++;
            $display("FAIL reset state: got busy=%b done=%b dbz=%b hi=%h lo=%h, required all 0",
                     busy_o, done_o, div_by_zero_o, hi_o, lo_o);
        end
        rst_n = 1'b1;
        @(negedge clk);

        // Directed cases
        issue(3'b000, 32'd12, -32'sd34);              wait_idle();
        issue(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF);  wait_idle();
        issue(3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF);  wait_idle();
        issue(3'b010, -32'sd7, 32'd2);                wait_idle();
        issue(3'b011, 32'd4321, 32'd1234);            wait_idle();
        issue(3'b010, 32'h8000_0000, 32'hFFFF_FFFF);  wait_idle();
        issue(3'b011, 32'd100, 32'd0);                wait_idle();
        issue(3'b101, 32'd5, 32'd0);                  wait_idle();
        issue(3'b100, 32'hDEAD_BEEF, 32'd0);          wait_idle();

        // Reserved opcodes: no done, HI/LO untouched
        issue(3'b110, 32'h1111_1111, 32'd3);
        issue(3'b111, 32'h2222_2222, 32'd0);
        repeat (3) @(negedge clk);
        checks++;
        if (hi_o !== m_hi || lo_o !== m_lo) begin
            errors++;
            $display("FAIL reserved op: got hi=%h lo=%h, required hi=%h lo=%h", hi_o, lo_o, m_hi, m_lo);
        end

        // Start while busy is ignored
        issue(3'b000, 32'h0001_2345, 32'hFFFF_0F0F);
        repeat (9) @(negedge clk);
        start_i = 1'b1; op_i = 3'b011; a_i = 32'd9; b_i = 32'd3;
        checks++;
        if (busy_o !== 1'b1) begin
            errors++;
            $display("FAIL busy during second start: got %b, required 1", busy_o);
        end
        @(negedge clk);
        start_i = 1'b0;
        wait_idle();

        // Async reset mid-divide
        issue(3'b010, 32'h7654_3210, 32'd13);
        repeat (14) @(negedge clk);
        rst_n = 1'b0;
        #1;
        sb_q.delete();
        busy_lo = 1; busy_hi = 0; m_hi = '0; m_lo = '0;
        checks++;
        if (busy_o !== 1'b0 || done_o !== 1'b0 || hi_o !== 32'd0 || lo_o !== 32'd0) begin
            errors++;
            $display("FAIL async reset: got busy=%b done=%b hi=%h lo=%h, required all 0",
                     busy_o, done_o, hi_o, lo_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        issue(3'b001, 32'd3, 32'd5);                  wait_idle();

        // Randomized traffic
        for (int n = 0; n < 60; n++) begin
            issue(3'($urandom_range(0, 5)), rnd_val(), rnd_val());
            wait_idle();
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global timeout: simulation did not finish, required finish");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
